// File: rtl/serial_clock_gen.sv
// -----------------------------------------------------------------------------
// serial_clock_gen
//   Programmable serial-clock generator. Divides CLK by a runtime divisor
//   (half-period = div+1 CLK cycles) and drives SERIAL_CLK with a selectable
//   idle polarity. Runs continuously (BURST_LEN=0) or for a counted number of
//   full SERIAL_CLK cycles, and always stops at the idle level.
//
// Ports
//   CLK        in   system clock, posedge
//   RST        in   asynchronous reset, active-high
//   DIV_VAL    in   divisor value for DIV_LOAD
//   DIV_LOAD   in   strobe: capture DIV_VAL into the shadow divisor
//   CPOL       in   idle level of SERIAL_CLK (tracked only while idle)
//   BURST_LEN  in   full cycles per run, 0 = continuous (sampled at START)
//   START      in   strobe: begin a run (idle only)
//   STOP       in   strobe: end the run at the next idle-level point
//   SERIAL_CLK out  divided clock, registered
//   RISE_TICK  out  pulse with each SERIAL_CLK 0->1 toggle
//   FALL_TICK  out  pulse with each SERIAL_CLK 1->0 toggle
//   BUSY       out  run in progress (drops one cycle after return to IDLE)
//   DONE       out  pulse when a run has finished
// -----------------------------------------------------------------------------
module serial_clock_gen #(
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(16'h003F),
  parameter int               BURST_W     = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CNT_W-1:0]   DIV_VAL,
  input  logic               DIV_LOAD,
  input  logic               CPOL,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               START,
  input  logic               STOP,
  output logic               SERIAL_CLK,
  output logic               RISE_TICK,
  output logic               FALL_TICK,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   div_act_q;
  logic [CNT_W-1:0]   div_sh_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] edges_q;
  logic               cpol_q;

  logic start_ok;
  logic at_idle;
  logic tc;
  logic last_full;

  // BUSY stays high for the cycle after the run re-enters IDLE, so gating
  // START with it also blocks a restart before DONE has been reported.
  assign start_ok  = START && !STOP && !BUSY;
  assign at_idle   = (SERIAL_CLK == cpol_q);
  // >= rather than == keeps the counter bounded even if the divisor shrank.
  assign tc        = (cnt_q >= div_act_q);
  // Widened by one bit so the +1 can never wrap into a false match.
  assign last_full = (burst_q != '0) &&
                     (({1'b0, edges_q} + 1'b1) == {1'b0, burst_q});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_act_q  <= DEFAULT_DIV;
      div_sh_q   <= DEFAULT_DIV;
      burst_q    <= '0;
      edges_q    <= '0;
      cpol_q     <= 1'b0;
      SERIAL_CLK <= 1'b0;
      RISE_TICK  <= 1'b0;
      FALL_TICK  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      RISE_TICK <= 1'b0;
      FALL_TICK <= 1'b0;
      // First idle cycle after a run: report completion, BUSY falls below.
      DONE      <= BUSY && (state_q == S_IDLE);
      if (DIV_LOAD) div_sh_q <= DIV_VAL;

      case (state_q)
        S_IDLE: begin
          cpol_q     <= CPOL;
          SERIAL_CLK <= CPOL;   // polarity change only, never a tick
          cnt_q      <= '0;
          BUSY       <= start_ok;
          if (DIV_LOAD) div_act_q <= DIV_VAL;
          if (start_ok) begin
            state_q <= S_RUN;
            burst_q <= BURST_LEN;
            edges_q <= '0;
          end
        end

        S_RUN: begin
          BUSY <= 1'b1;
          if (STOP && at_idle) begin
            // Already at idle level: stop here, suppressing any toggle away.
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (tc) begin
            cnt_q      <= '0;
            SERIAL_CLK <= ~SERIAL_CLK;
            RISE_TICK  <= ~SERIAL_CLK;
            FALL_TICK  <= SERIAL_CLK;
            div_act_q  <= div_sh_q;   // new divisor only on half-period boundary
            if (!at_idle) begin
              // This toggle returns to idle level: one full cycle completed.
              if (burst_q != '0) edges_q <= edges_q + 1'b1;
              if (STOP || last_full) state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (STOP) state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          BUSY <= 1'b1;
          if (tc) begin
            // Always the toggle back to idle level.
            cnt_q      <= '0;
            SERIAL_CLK <= ~SERIAL_CLK;
            RISE_TICK  <= ~SERIAL_CLK;
            FALL_TICK  <= SERIAL_CLK;
            div_act_q  <= div_sh_q;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_serial_clock_gen
//   Directed scenarios followed by random stimulus, each cycle compared against
//   a behavioural model that tracks "cycles remaining in this half-period",
//   the current level and the number of completed full cycles.
// -----------------------------------------------------------------------------
module tb_serial_clock_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] DIV_VAL;
  logic        DIV_LOAD;
  logic        CPOL;
  logic [7:0]  BURST_LEN;
  logic        START;
  logic        STOP;
  logic        SERIAL_CLK, RISE_TICK, FALL_TICK, BUSY, DONE;

  serial_clock_gen dut (
    .CLK(CLK), .RST(RST), .DIV_VAL(DIV_VAL), .DIV_LOAD(DIV_LOAD), .CPOL(CPOL),
    .BURST_LEN(BURST_LEN), .START(START), .STOP(STOP), .SERIAL_CLK(SERIAL_CLK),
    .RISE_TICK(RISE_TICK), .FALL_TICK(FALL_TICK), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n_rise, n_fall, n_done;

  // model: phase 0 idle, 1 running, 2 draining
  int m_phase, m_rem, m_act, m_shadow, m_blen, m_nfull;
  bit m_sclk, m_rise, m_fall, m_busy, m_done, m_pol;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_act = 'h3F; m_shadow = 'h3F; m_blen = 0; m_nfull = 0;
    m_sclk = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_done = 0; m_pol = 0;
  endtask

  task automatic flip(input int new_div);
    m_sclk = !m_sclk;
    m_rise = m_sclk;
    m_fall = !m_sclk;
    m_act  = new_div;
    m_rem  = m_act + 1;
  endtask

  task automatic model_edge();
    int  old_sh;
    bit  go;
    if (RST) begin model_reset(); return; end
    old_sh = m_shadow;
    m_rise = 0; m_fall = 0; m_done = 0;
    if (DIV_LOAD) m_shadow = DIV_VAL;
    case (m_phase)
      0: begin
        go     = START && !STOP && !m_busy;
        m_done = m_busy;
        if (DIV_LOAD) m_act = DIV_VAL;
        m_pol  = CPOL;
        m_sclk = CPOL;
        m_busy = go;
        if (go) begin
          m_phase = 1; m_rem = m_act + 1; m_blen = BURST_LEN; m_nfull = 0;
        end
      end
      1: begin
        if (STOP && m_sclk == m_pol) m_phase = 0;
        else if (m_rem == 1) begin
          flip(old_sh);
          if (m_sclk == m_pol) begin
            m_nfull++;
            if (STOP || (m_blen != 0 && m_nfull == m_blen)) m_phase = 0;
          end
        end else begin
          m_rem--;
          if (STOP) m_phase = 2;
        end
      end
      default: begin
        if (m_rem == 1) begin flip(old_sh); m_phase = 0; end
        else m_rem--;
      end
    endcase
  endtask

  task automatic compare();
    chk("sclk", SERIAL_CLK, m_sclk);
    chk("rise", RISE_TICK, m_rise);
    chk("fall", FALL_TICK, m_fall);
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done);
    n_rise += RISE_TICK;
    n_fall += FALL_TICK;
    n_done += DONE;
  endtask

  // one CLK cycle: model follows the edge, outputs checked on the falling edge,
  // then strobes are cleared
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
    START = 0; STOP = 0; DIV_LOAD = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_cnt();
    n_rise = 0; n_fall = 0; n_done = 0;
  endtask

  initial begin
    bit found;
    RST = 1; DIV_VAL = 0; DIV_LOAD = 0; CPOL = 0; BURST_LEN = 0; START = 0; STOP = 0;
    model_reset();
    clr_cnt();
    @(negedge CLK);
    compare();                      // reset state
    @(negedge CLK);
    RST = 0;

    // T1: default divisor, continuous
    START = 1;
    clr_cnt();
    steps(300);
    chk("t1_no_done", n_done, 0);
    chk("t1_rises", n_rise, 2);     // toggles at 64,128,192,256 after start
    STOP = 1;
    steps(80);

    // T2: divisor 2, idle high, burst of 3
    DIV_VAL = 2; DIV_LOAD = 1; CPOL = 1;
    step();
    chk("t2_idle_hi", SERIAL_CLK, 1);
    clr_cnt();
    BURST_LEN = 3; START = 1;
    steps(40);
    chk("t2_rises", n_rise, 3);
    chk("t2_falls", n_fall, 3);
    chk("t2_dones", n_done, 1);
    chk("t2_end_lvl", SERIAL_CLK, 1);
    chk("t2_busy", BUSY, 0);

    // T3: divisor 4, stop while high
    CPOL = 0; DIV_VAL = 4; DIV_LOAD = 1; BURST_LEN = 0;
    step();
    START = 1;
    step();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (m_sclk) found = 1;
    end
    chk("t3_wait_hi", found, 1);
    step();
    STOP = 1;
    clr_cnt();
    steps(20);
    chk("t3_falls", n_fall, 1);
    chk("t3_dones", n_done, 1);
    chk("t3_low", SERIAL_CLK, 0);

    // T4: divisor change mid half-period
    DIV_VAL = 7; DIV_LOAD = 1;
    step();
    START = 1;
    steps(12);
    DIV_VAL = 1; DIV_LOAD = 1;
    steps(30);
    STOP = 1;
    steps(20);

    // T5: divisor 0, burst 2
    DIV_VAL = 0; DIV_LOAD = 1; BURST_LEN = 2;
    step();
    START = 1;
    clr_cnt();
    steps(10);
    chk("t5_rises", n_rise, 2);
    chk("t5_dones", n_done, 1);

    // T6: reset mid-run, then START+STOP together
    DIV_VAL = 3; DIV_LOAD = 1; BURST_LEN = 0;
    step();
    START = 1;
    steps(9);
    RST = 1;
    #1;
    chk("t6_sclk", SERIAL_CLK, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_rise", RISE_TICK, 0);
    model_reset();
    step();
    RST = 0;
    clr_cnt();
    START = 1; STOP = 1;
    steps(5);
    chk("t6_st_busy", BUSY, 0);
    chk("t6_no_done", n_done, 0);
    START = 1;                      // divisor back to 3F after reset
    steps(70);
    STOP = 1;
    steps(140);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin DIV_VAL = 16'($urandom_range(5)); DIV_LOAD = 1; end
      if ($urandom_range(15) == 0) CPOL = ~CPOL;
      BURST_LEN = 8'($urandom_range(3));
      START = ($urandom_range(9) == 0);
      STOP  = ($urandom_range(39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
